// File: rtl/lp_pkg.sv
// Shared types for the LP solver feeder: one constraint row, FSM state, and dimensions.
package lp_pkg;

  localparam int NUM_ROWS = 7;
  localparam int A_W      = 6;
  localparam int B_W      = 12;
  localparam int ADDR_W   = 3;

  typedef struct packed {
    logic signed [A_W-1:0] a1;
    logic signed [A_W-1:0] a2;
    logic signed [B_W-1:0] b;
  } row_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/lp_row_file.sv
// Seven-row problem store: single write port, combinational read, async clear.
// Writes to address 7 are discarded; reads of address 7 return zero.
module lp_row_file
  import lp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  row_t              wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output row_t              rdata_o
);

  localparam logic [ADDR_W-1:0] ROWS_A = ADDR_W'(NUM_ROWS);

  row_t rows_q [NUM_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows_q[i] <= '0;
      end
    end else if (we_i && (waddr_i < ROWS_A)) begin
      rows_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (raddr_i < ROWS_A) begin
      rdata_o = rows_q[raddr_i];
    end
  end

endmodule

// File: rtl/lp_feeder.sv
// Streams a 7-row LP problem to the solver one row per cycle after start, then waits
// for the solver result (bounded by TIMEOUT) and reports it to the host with a one-cycle pulse.
module lp_feeder
  import lp_pkg::*;
#(
  parameter int TIMEOUT = 4194304,
  parameter int TO_W    = 23
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic signed [A_W-1:0] cfg_a1,
  input  logic signed [A_W-1:0] cfg_a2,
  input  logic signed [B_W-1:0] cfg_b,
  input  logic                  start,
  output logic                  busy,
  output logic                  lp_valid,
  output logic signed [A_W-1:0] lp_a1,
  output logic signed [A_W-1:0] lp_a2,
  output logic signed [B_W-1:0] lp_b,
  input  logic                  lp_out_valid,
  input  logic signed [B_W-1:0] lp_out_max_value,
  output logic                  res_valid,
  output logic signed [B_W-1:0] res_value,
  output logic                  res_timeout
);

  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_ROWS);

  state_e                state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [TO_W-1:0]       cnt_q;
  logic                  busy_q;
  logic                  lp_valid_q;
  row_t                  lp_row_q;
  logic                  res_valid_q;
  logic signed [B_W-1:0] res_value_q;
  logic                  res_timeout_q;

  logic              wr_en;
  logic [ADDR_W-1:0] raddr;
  row_t              cfg_row;
  row_t              rd_row;
  row_t              row0_d;

  assign wr_en   = cfg_we && (state_q == IDLE);
  assign raddr   = (state_q == SEND) ? idx_q : '0;
  assign cfg_row = '{a1: cfg_a1, a2: cfg_a2, b: cfg_b};

  // Row 0 is launched on the same edge that writes it, so forward the host data.
  assign row0_d = (wr_en && (cfg_addr == '0)) ? cfg_row : rd_row;

  lp_row_file u_row_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_row),
    .raddr_i (raddr),
    .rdata_o (rd_row)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      lp_valid_q    <= 1'b0;
      lp_row_q      <= '0;
      res_valid_q   <= 1'b0;
      res_value_q   <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (start) begin
            state_q    <= SEND;
            busy_q     <= 1'b1;
            lp_valid_q <= 1'b1;
            lp_row_q   <= row0_d;
            idx_q      <= ADDR_W'(1);
          end
        end
        SEND: begin
          if (idx_q == LAST_IDX) begin
            state_q    <= WAIT;
            lp_valid_q <= 1'b0;
            lp_row_q   <= '0;
            cnt_q      <= '0;
          end else begin
            lp_row_q <= rd_row;
            idx_q    <= idx_q + ADDR_W'(1);
          end
        end
        WAIT: begin
          if (lp_out_valid) begin
            state_q       <= DONE;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_value_q   <= lp_out_max_value;
            res_timeout_q <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q       <= DONE;
            busy_q        <= 1'b0;
            res_valid_q   <= 1'b1;
            res_value_q   <= '0;
            res_timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        DONE: begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign lp_valid    = lp_valid_q;
  assign lp_a1       = lp_row_q.a1;
  assign lp_a2       = lp_row_q.a2;
  assign lp_b        = lp_row_q.b;
  assign res_valid   = res_valid_q;
  assign res_value   = res_value_q;
  assign res_timeout = res_timeout_q;

endmodule
